// File: rtl/hb_task_pkg.sv
// hb_task_pkg: shared types and helpers for the hardware task queue dispatcher.
// Revision: 1.0
`default_nettype none

package hb_task_pkg;

    localparam int TASK_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SELECT = 2'd2,
        OFFER  = 2'd3
    } disp_state_t;

    // Index width for a lane count; never narrower than one bit.
    function automatic int wid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hb_rr_arbiter.sv
// hb_rr_arbiter: combinational round-robin pick of the first request at or above ptr.
// Revision: 1.0
`default_nettype none

module hb_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any_grant
);

    int j;

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        j         = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                grant     = '0;
                grant[j]  = 1'b1;
                idx       = IDX_W'(j);
                any_grant = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hb_task_dispatcher.sv
// hb_task_dispatcher: pops task words from the queue head and offers each to an idle worker lane.
// Revision: 1.0
`default_nettype none

module hb_task_dispatcher
    import hb_task_pkg::*;
#(
    parameter int WIDTH       = TASK_WIDTH,
    parameter int NUM_WORKERS = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   q_valid,
    input  logic [WIDTH-1:0]       q_data,
    output logic                   q_pop,
    output logic [NUM_WORKERS-1:0] wk_valid,
    output logic [WIDTH-1:0]       wk_data,
    input  logic [NUM_WORKERS-1:0] wk_ready,
    input  logic [NUM_WORKERS-1:0] wk_done,
    output logic [NUM_WORKERS-1:0] busy_mask,
    output logic [CNT_W-1:0]       dispatch_count,
    output logic                   idle
);

    localparam int WID_W = wid_w(NUM_WORKERS);

    disp_state_t            state;
    disp_state_t            state_next;
    logic [WIDTH-1:0]       task_reg;
    logic [NUM_WORKERS-1:0] busy;
    logic [NUM_WORKERS-1:0] req;
    logic [NUM_WORKERS-1:0] grant;
    logic [NUM_WORKERS-1:0] sel_onehot;
    logic [NUM_WORKERS-1:0] accept_onehot;
    logic [WID_W-1:0]       rr_ptr;
    logic [WID_W-1:0]       sel;
    logic [WID_W-1:0]       grant_idx;
    logic [WID_W-1:0]       sel_plus1;
    logic                   any_grant;
    logic                   accept;
    logic                   latch_sel;
    logic [CNT_W-1:0]       count;

    assign req = ~busy;

    hb_rr_arbiter #(
        .N     (NUM_WORKERS),
        .IDX_W (WID_W)
    ) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .idx       (grant_idx),
        .any_grant (any_grant)
    );

    assign accept        = (state == OFFER) && wk_ready[sel];
    assign accept_onehot = accept ? sel_onehot : '0;
    assign sel_plus1     = (sel == WID_W'(NUM_WORKERS - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        q_pop      = 1'b0;
        wk_valid   = '0;
        latch_sel  = 1'b0;
        case (state)
            IDLE: begin
                if (en && q_valid) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                q_pop      = 1'b1;
                state_next = SELECT;
            end
            SELECT: begin
                if (any_grant) begin
                    latch_sel  = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                wk_valid = sel_onehot;
                if (accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Done and accept may hit the same edge on different lanes; both apply.
    always_ff @(posedge clk) begin
        if (reset) begin
            task_reg   <= '0;
            busy       <= '0;
            rr_ptr     <= '0;
            sel        <= '0;
            sel_onehot <= '0;
            count      <= '0;
        end else begin
            if (state == FETCH) begin
                task_reg <= q_data;
            end
            if (latch_sel) begin
                sel        <= grant_idx;
                sel_onehot <= grant;
            end
            busy <= (busy & ~wk_done) | accept_onehot;
            if (accept) begin
                rr_ptr <= sel_plus1;
                count  <= count + 1'b1;
            end
        end
    end

    assign wk_data        = task_reg;
    assign busy_mask      = busy;
    assign dispatch_count = count;
    assign idle           = (state == IDLE) && (busy == '0);

endmodule

`default_nettype wire

// File: tb/tb_hb_task_dispatcher.sv
// tb_hb_task_dispatcher: table/scoreboard bench for hb_task_dispatcher.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_hb_task_dispatcher;

    localparam int W  = 32;
    localparam int NW = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          q_valid;
    logic [W-1:0]  q_data;
    logic          q_pop;
    logic [NW-1:0] wk_valid;
    logic [W-1:0]  wk_data;
    logic [NW-1:0] wk_ready;
    logic [NW-1:0] wk_done;
    logic [NW-1:0] busy_mask;
    logic [CW-1:0] dispatch_count;
    logic          idle;

    always #5 clk = ~clk;

    // Simple queue model: head word visible combinationally, advances after a popped edge.
    logic [W-1:0] qmem [0:255];
    int qhead = 0;
    int qtail = 0;
    assign q_valid = (qhead != qtail);
    assign q_data  = qmem[qhead[7:0]];

    hb_task_dispatcher #(
        .WIDTH       (W),
        .NUM_WORKERS (NW),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .q_valid        (q_valid),
        .q_data         (q_data),
        .q_pop          (q_pop),
        .wk_valid       (wk_valid),
        .wk_data        (wk_data),
        .wk_ready       (wk_ready),
        .wk_done        (wk_done),
        .busy_mask      (busy_mask),
        .dispatch_count (dispatch_count),
        .idle           (idle)
    );

    typedef struct {
        logic [NW-1:0] w;
        logic [W-1:0]  d;
    } exp_t;

    typedef struct {
        logic [W-1:0]  data;
        int            worker;
        logic [NW-1:0] busy;
    } vec_t;

    exp_t exp_q[$];
    vec_t rr_tab[4];

    int checks    = 0;
    int failures  = 0;
    int pop_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_task(input logic [W-1:0] d, input int worker);
        exp_t e;
        qmem[qtail[7:0]] = d;
        qtail++;
        e.w = NW'(1) << worker;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // One clock: monitor on the falling edge, return 1ns after the rising edge.
    task automatic tick();
        bit   popped;
        exp_t e;
        @(negedge clk);
        popped = q_pop && !reset;
        if (popped) begin
            pop_count++;
            chk("pop_needs_valid", q_valid, 1);
        end
        if (!reset && ((wk_valid & wk_ready) != '0)) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_accept", wk_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_worker", wk_valid, e.w);
                chk("sb_data", wk_data, e.d);
            end
        end
        @(posedge clk);
        #1;
        if (popped) qhead++;
    endtask

    task automatic wait_offer(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (wk_valid != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("offer_timeout", ok, 1);
    endtask

    task automatic wait_accept(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((wk_valid & wk_ready) != '0) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("accept_timeout", ok, 1);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        en       = 1'b1;
        wk_ready = '0;
        wk_done  = '0;
        tick();
        tick();
        exp_q.delete();
        qhead = qtail;
        reset = 1'b0;
        tick();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_q_pop"}, q_pop, 0);
        chk({tag, "_wk_valid"}, wk_valid, 0);
        chk({tag, "_wk_data"}, wk_data, 0);
        chk({tag, "_busy"}, busy_mask, 0);
        chk({tag, "_count"}, dispatch_count, 0);
        chk({tag, "_idle"}, idle, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int pc;

        rr_tab[0] = '{data: 32'hA000_0000, worker: 0, busy: 4'b0001};
        rr_tab[1] = '{data: 32'hA000_0001, worker: 1, busy: 4'b0011};
        rr_tab[2] = '{data: 32'hA000_0002, worker: 2, busy: 4'b0111};
        rr_tab[3] = '{data: 32'hA000_0003, worker: 3, busy: 4'b1111};

        reset    = 1'b1;
        en       = 1'b1;
        wk_ready = '0;
        wk_done  = '0;
        do_reset();
        chk_reset_values("reset");

        // Single task latency
        wk_ready = 4'hF;
        pc = pop_count;
        push_task(32'hDEAD_BEEF, 0);
        tick();
        chk("single_pop_n1", q_pop, 1);
        tick();
        chk("single_pop_n2", q_pop, 0);
        tick();
        chk("single_wk_valid", wk_valid, 4'b0001);
        chk("single_wk_data", wk_data, 32'hDEAD_BEEF);
        tick();
        chk("single_busy", busy_mask, 4'b0001);
        chk("single_count", dispatch_count, 1);
        chk("single_pops", pop_count - pc, 1);
        wk_done = 4'b0001;
        tick();
        wk_done = '0;
        chk("single_busy_clr", busy_mask, 0);
        chk("single_idle", idle, 1);

        // Round-robin across all lanes, fifth task waits for a free lane
        do_reset();
        wk_ready = 4'hF;
        pc = pop_count;
        for (int i = 0; i < 4; i++) begin
            push_task(rr_tab[i].data, rr_tab[i].worker);
            wait_accept(12, ok);
            chk("rr_busy", busy_mask, rr_tab[i].busy);
            chk("rr_count", dispatch_count, i + 1);
        end
        push_task(32'hA000_0004, 2);
        repeat (8) tick();
        chk("rr_wait_no_offer", wk_valid, 0);
        chk("rr_wait_pops", pop_count - pc, 5);
        chk("rr_wait_busy", busy_mask, 4'b1111);
        wk_done = 4'b0100;
        tick();
        wk_done = '0;
        wait_accept(12, ok);
        chk("rr_fifth_busy", busy_mask, 4'b1111);
        chk("rr_fifth_count", dispatch_count, 5);
        chk("rr_fifth_pops", pop_count - pc, 5);

        // Backpressure on the selected lane
        do_reset();
        pc = pop_count;
        push_task(32'h1234_5678, 0);
        wait_offer(12, ok);
        for (int i = 0; i < 6; i++) begin
            chk("bp_wk_valid", wk_valid, 4'b0001);
            chk("bp_wk_data", wk_data, 32'h1234_5678);
            chk("bp_count", dispatch_count, 0);
            tick();
        end
        chk("bp_pops", pop_count - pc, 1);
        wk_ready = 4'hF;
        wait_accept(12, ok);
        chk("bp_count_after", dispatch_count, 1);
        chk("bp_busy_after", busy_mask, 4'b0001);

        // Done on lane 0 with accept on lane 1, plus a stray done on idle lane 3
        push_task(32'h5151_0001, 1);
        wait_offer(12, ok);
        chk("sim_offer", wk_valid, 4'b0010);
        chk("sim_busy_before", busy_mask, 4'b0001);
        wk_done = 4'b1001;
        tick();
        wk_done = '0;
        chk("sim_busy_after", busy_mask, 4'b0010);
        chk("sim_count", dispatch_count, 2);
        wk_done = 4'b0010;
        tick();
        wk_done = '0;

        // en gating, en drop during OFFER, empty queue
        do_reset();
        en = 1'b0;
        wk_ready = 4'hF;
        pc = pop_count;
        push_task(32'hCAFE_0001, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("en_no_pop", q_pop, 0);
            chk("en_idle", idle, 1);
        end
        chk("en_pops", pop_count - pc, 0);
        en = 1'b1;
        wait_offer(12, ok);
        en = 1'b0;
        wk_ready = '0;
        tick();
        tick();
        chk("en_drop_offer", wk_valid, 4'b0001);
        wk_ready = 4'hF;
        wait_accept(12, ok);
        chk("en_drop_count", dispatch_count, 1);
        chk("en_drop_busy", busy_mask, 4'b0001);
        wk_done = 4'b0001;
        tick();
        wk_done = '0;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("empty_idle", idle, 1);
            chk("empty_no_pop", q_pop, 0);
        end
        chk("empty_pops", pop_count - pc, 1);

        // Reset while offering to lane 2
        do_reset();
        wk_ready = 4'hF;
        push_task(32'h0000_0011, 0);
        wait_accept(12, ok);
        push_task(32'h0000_0022, 1);
        wait_accept(12, ok);
        wk_ready = '0;
        push_task(32'h0000_0033, 2);
        wait_offer(12, ok);
        chk("rst_offer", wk_valid, 4'b0100);
        reset = 1'b1;
        tick();
        chk_reset_values("rst_mid");
        exp_q.delete();
        reset = 1'b0;
        tick();
        chk("rst_idle_after", idle, 1);
        wk_ready = 4'hF;
        push_task(32'h0000_0044, 0);
        wait_accept(12, ok);
        chk("rst_next_busy", busy_mask, 4'b0001);
        chk("rst_next_count", dispatch_count, 1);

        // Counter wrap with lanes released after each accept
        do_reset();
        wk_ready = 4'hF;
        for (int i = 0; i < 9; i++) begin
            push_task(32'h0000_0900 + i, i % NW);
            wait_accept(12, ok);
            chk("wrap_count", dispatch_count, (i + 1) % (1 << CW));
            wk_done = NW'(1) << (i % NW);
            tick();
            wk_done = '0;
        end

        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hb_task_dispatcher.md
# hb_task_dispatcher

Consumer-side engine for the hardware task queue: pops task words from the queue's head and hands each one to one of `NUM_WORKERS` worker lanes. Sits between the queue's read port (`valid_out`/`data_out`/`pop_req`) and the worker array. Tracks per-worker busy state from acceptance until completion, and selects workers round-robin among idle lanes.

## Interface
- `WIDTH`, 32: task word width; must match the queue.
- `NUM_WORKERS`, 4: number of worker lanes; must be at least 2.
- `CNT_W`, 16: width of the dispatched-task counter.

Clock and reset: clk, synchronous, active-high reset named `reset`.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: when low, the block starts no new fetch; an in-flight task still completes.
- `q_valid` in 1: queue non-empty; connects to the queue's `valid_out`.
- `q_data` in WIDTH: head task word, combinational from the queue.
- `q_pop` out 1: one-cycle pop strobe; connects to the queue's `pop_req`.
- `wk_valid` out NUM_WORKERS: one-hot offer to the selected worker.
- `wk_data` out WIDTH: task word, shared by all lanes.
- `wk_ready` in NUM_WORKERS: per-worker accept.
- `wk_done` in NUM_WORKERS: per-worker one-cycle completion pulse.
- `busy_mask` out NUM_WORKERS: registered busy flags.
- `dispatch_count` out CNT_W: number of accepted tasks; wraps modulo 2^CNT_W.
- `idle` out 1: asserted when the FSM is in IDLE and `busy_mask` is 0.

## Operation

FSM states:
- **IDLE**: if `en && q_valid`, go to FETCH.
- **FETCH**: `q_pop`=1 for exactly this cycle. `task_reg` is loaded from `q_data` at the same edge. Go to SELECT unconditionally.
- **SELECT**: if any bit of `~busy_mask` is set, latch `sel` and go to OFFER. Otherwise stay in SELECT.
- **OFFER**: `wk_valid[sel]`=1 and `wk_data`=`task_reg`. Hold both stable until `wk_ready[sel]`. On the handshake edge:
  - set `busy[sel]`
  - set `rr_ptr` to (`sel`+1) mod NUM_WORKERS
  - increment `dispatch_count`
  - go to IDLE

Worker selection and busy tracking:
- `sel` is the first idle index scanning upward from `rr_ptr`, wrapping at NUM_WORKERS.
- `busy_next` = (`busy` & ~`wk_done`) | `accept_onehot`.
- `wk_done` on a lane that is not busy is ignored.
- `wk_ready` on a non-selected lane, or outside OFFER, is ignored.
- `en` is sampled only in IDLE. Dropping `en` in any other state does not abort the task.

`wk_data` holds `task_reg` in all states. It is only meaningful while `wk_valid` is high.

Reset behaviour:
- FSM goes to IDLE.
- `q_pop`=0, `wk_valid`=0, `wk_data`=0, `task_reg`=0.
- `busy_mask`=0, `rr_ptr`=0, `dispatch_count`=0.
- `idle`=1 in the cycle after reset deasserts.

Reset mid-operation: a task popped but not yet accepted (in SELECT or OFFER) is discarded. Busy flags are cleared; the workers are reset by the same `reset`.

## Timing
- Pipeline from the queue to a worker:
  - Cycle n: `q_valid`=1 in IDLE.
  - Cycle n+1: `q_pop`=1 (FETCH).
  - Cycle n+2: SELECT.
  - Cycle n+3: earliest `wk_valid`.
- Minimum spacing is 4 cycles per task: IDLE→FETCH→SELECT→OFFER, with accept in the first OFFER cycle.
- The queue's head advances at the FETCH edge. The block never pops while `q_valid`=0, and never pops twice per task.
- Busy clear and set are visible in `busy_mask` on the cycle after the `wk_done` or accept edge.
- A `wk_done` pulse in SELECT makes the worker selectable on the following cycle.
- `dispatch_count` wraps from 2^CNT_W−1 to 0.
- `idle` is combinational from registered state.

## Structure
- Shared package `hb_task_pkg`:
  - FSM state enum `disp_state_t` (IDLE, FETCH, SELECT, OFFER)
  - default `TASK_WIDTH`=32
  - `WID_W` = $clog2(NUM_WORKERS) helper
- Sub-module `hb_rr_arbiter`: combinational.
  - Inputs: request mask (`~busy`) and `rr_ptr`.
  - Outputs: one-hot grant, encoded index, `any_grant`.
  - Reusable by future multi-queue schedulers.
- Everything else stays in the top module: FSM, `task_reg`, busy register, counter.

## Test plan
- **Single task**: after reset, push 0xDEADBEEF with all `wk_ready`=1.
  - `q_pop` is high one cycle later.
  - `wk_valid`=4'b0001 and `wk_data`=0xDEADBEEF 3 cycles after `q_valid`.
  - `busy_mask`=0001 and `dispatch_count`=1 after accept.
- **Round-robin**: 5 tasks, no `wk_done`. Grants go to workers 0,1,2,3. The fifth task waits in SELECT with `q_pop` seen exactly 5 times. Pulse `wk_done[2]`: the fifth task goes to worker 2 and `busy_mask` returns to 1111.
- **Backpressure**: hold `wk_ready[sel]`=0 for 6 cycles. `wk_valid` and `wk_data` stay stable, there is no further `q_pop`, and `dispatch_count` is unchanged until the accept.
- **Simultaneous events**: `wk_done[0]` on the same edge as accept to worker 1. `busy_mask` goes 0001→0010. A stray `wk_done[3]` with lane 3 idle has no effect.
- **en gating and empty queue**:
  - `en`=0 with `q_valid`=1: no `q_pop`, `idle` stays 1.
  - Deassert `en` during OFFER: the task still completes.
  - `q_valid`=0: the FSM stays in IDLE.
- **Reset mid-OFFER**: assert `reset` while `wk_valid`=0100. The next cycle shows all outputs at their reset values. The next task goes to worker 0.
